// File: rtl/ising_lattice_engine_pkg.sv
// Shared constants, FSM state type and LFSR step for the Ising lattice engine.
package ising_lattice_engine_pkg;

  localparam logic SpinUp = 1'b1;

  localparam logic [31:0] LfsrMask  = 32'h80200003;
  localparam logic [31:0] LfsrReset = 32'hACE10001;
  localparam logic [31:0] HashConst = 32'h9E3779B9;

  typedef enum logic [2:0] {StIdle, StWhite, StGrey, StMeas, StFin} state_e;

  // Galois form, shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LfsrMask) : (x >> 1);
  endfunction

endpackage

// File: rtl/ising_lattice_engine_if.sv
// Host-side control, load/readback and observable bundle of the Ising lattice engine.
interface ising_lattice_engine_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned SWEEP_W = 16
);
  localparam int unsigned RW  = $clog2(N);
  localparam int unsigned E_W = $clog2(2 * N * N) + 2;

  logic                      start;
  logic                      abort;
  logic [SWEEP_W-1:0]        num_sweeps;
  logic [31:0]               seed;
  logic [31:0]               thr4;
  logic [31:0]               thr8;
  logic                      load_en;
  logic [RW-1:0]             load_row;
  logic [N-1:0]              load_data;
  logic [RW-1:0]             rd_row;
  logic [N-1:0]              rd_data;
  logic                      busy;
  logic                      done;
  logic                      obs_valid;
  logic signed [E_W-1:0]     energy;
  logic signed [E_W-1:0]     magnet;
  logic [SWEEP_W-1:0]        sweep_cnt;

  modport master (
    output start, abort, num_sweeps, seed, thr4, thr8, load_en, load_row, load_data, rd_row,
    input  rd_data, busy, done, obs_valid, energy, magnet, sweep_cnt
  );

  modport slave (
    input  start, abort, num_sweeps, seed, thr4, thr8, load_en, load_row, load_data, rd_row,
    output rd_data, busy, done, obs_valid, energy, magnet, sweep_cnt
  );

endinterface

// File: rtl/ising_lattice_engine_spin_cell.sv
// One Metropolis site: decides the next spin from its own value, four neighbours and a random word.
module ising_lattice_engine_spin_cell (
  input  logic        s,
  input  logic        n_up,
  input  logic        n_dn,
  input  logic        n_lt,
  input  logic        n_rt,
  input  logic [31:0] r,
  input  logic [31:0] thr4,
  input  logic [31:0] thr8,
  input  logic        en,
  output logic        s_next
);

  logic [2:0] aligned;
  logic       flip;

  // dE = 4*aligned - 8, so aligned<=2 is dE<=0, 3 is +4, 4 is +8
  always_comb begin
    aligned = 3'(n_up ~^ s) + 3'(n_dn ~^ s) + 3'(n_lt ~^ s) + 3'(n_rt ~^ s);
    case (aligned)
      3'd3:    flip = (r < thr4);
      3'd4:    flip = (r < thr8);
      default: flip = 1'b1;
    endcase
    s_next = (en && flip) ? ~s : s;
  end

endmodule

// File: rtl/ising_lattice_engine.sv
// NxN periodic Ising lattice with checkerboard Metropolis sweeps and row-serial observables.
module ising_lattice_engine
  import ising_lattice_engine_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned MEAS_EVERY = 1,
  parameter int unsigned SWEEP_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  ising_lattice_engine_if.slave host
);

  localparam int unsigned RW  = $clog2(N);
  localparam int unsigned E_W = $clog2(2 * N * N) + 2;
  localparam int unsigned PhW = (MEAS_EVERY > 1) ? $clog2(MEAS_EVERY) : 1;
  localparam logic signed [E_W-1:0] TwoN = E_W'(2 * N);
  localparam logic signed [E_W-1:0] OneN = E_W'(N);

  state_e state_q, state_d;

  logic [N-1:0]          spin_q [N];
  logic [N*N-1:0]        spin_nxt;
  logic [31:0]           lfsr_q;
  logic [SWEEP_W-1:0]    sweep_q, nsw_q, sweep_inc;
  logic [PhW-1:0]        ph_q;
  logic [RW-1:0]         row_q, row_nx;
  logic signed [E_W-1:0] e_acc_q, m_acc_q, e_acc_d, m_acc_d;
  logic signed [E_W-1:0] energy_q, magnet_q, eq_cnt, up_cnt;
  logic [N-1:0]          row_cur, row_dn;
  logic                  obs_q, done_q;
  logic                  start_acc, load_acc, upd_white, upd_grey, upd;
  logic                  ph_last, sample_due, meas_last;

  assign start_acc  = (state_q == StIdle) && host.start;
  assign load_acc   = (state_q == StIdle) && host.load_en;
  assign upd_white  = (state_q == StWhite) && !host.abort;
  assign upd_grey   = (state_q == StGrey) && !host.abort;
  assign upd        = upd_white || upd_grey;
  assign sweep_inc  = sweep_q + 1'b1;
  assign ph_last    = (ph_q == PhW'(MEAS_EVERY - 1));
  assign sample_due = ph_last || (sweep_inc == nsw_q);
  assign meas_last  = (state_q == StMeas) && (row_q == RW'(N - 1));
  assign row_nx     = row_q + 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      localparam int unsigned Idx = i * N + j;
      localparam logic [31:0] CellHash = 32'(Idx) * HashConst;
      ising_lattice_engine_spin_cell u_cell (
        .s      (spin_q[i][j]),
        .n_up   (spin_q[(i + N - 1) % N][j]),
        .n_dn   (spin_q[(i + 1) % N][j]),
        .n_lt   (spin_q[i][(j + N - 1) % N]),
        .n_rt   (spin_q[i][(j + 1) % N]),
        .r      (lfsr_q ^ CellHash),
        .thr4   (host.thr4),
        .thr8   (host.thr8),
        .en     ((((i + j) % 2) == 0) ? upd_white : upd_grey),
        .s_next (spin_nxt[Idx])
      );
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) spin_q[i] <= {N{SpinUp}};
    end else if (load_acc) begin
      spin_q[host.load_row] <= host.load_data;
    end else if (upd) begin
      for (int i = 0; i < N; i++) spin_q[i] <= spin_nxt[i*N +: N];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (host.start) state_d = (host.num_sweeps == '0) ? StMeas : StWhite;
      StWhite: state_d = StGrey;
      StGrey:  state_d = sample_due ? StMeas : StWhite;
      StMeas:  if (meas_last) state_d = (sweep_q == nsw_q) ? StFin : StWhite;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (host.abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Row k contributes its right bonds, its down bonds and its spins
  always_comb begin
    row_cur = spin_q[row_q];
    row_dn  = spin_q[row_nx];
    eq_cnt  = '0;
    up_cnt  = '0;
    for (int j = 0; j < N; j++) begin
      eq_cnt = eq_cnt + E_W'(row_cur[j] ~^ row_cur[(j + 1) % N]);
      eq_cnt = eq_cnt + E_W'(row_cur[j] ~^ row_dn[j]);
      up_cnt = up_cnt + E_W'(row_cur[j]);
    end
    e_acc_d = ((row_q == '0) ? '0 : e_acc_q) + (TwoN - (eq_cnt <<< 1));
    m_acc_d = ((row_q == '0) ? '0 : m_acc_q) + ((up_cnt <<< 1) - OneN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q   <= LfsrReset;
      sweep_q  <= '0;
      nsw_q    <= '0;
      ph_q     <= '0;
      row_q    <= '0;
      e_acc_q  <= '0;
      m_acc_q  <= '0;
      energy_q <= '0;
      magnet_q <= '0;
      obs_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      obs_q  <= 1'b0;
      done_q <= (state_q == StFin) && !host.abort;
      if (start_acc) begin
        lfsr_q  <= (host.seed == '0) ? 32'h1 : host.seed;
        sweep_q <= '0;
        nsw_q   <= host.num_sweeps;
        ph_q    <= '0;
      end
      if (upd) lfsr_q <= lfsr_step(lfsr_q);
      if (upd_grey) begin
        sweep_q <= sweep_inc;
        ph_q    <= ph_last ? '0 : ph_q + 1'b1;
      end
      if ((state_q == StMeas) && !host.abort) begin
        row_q   <= row_nx;
        e_acc_q <= e_acc_d;
        m_acc_q <= m_acc_d;
        if (meas_last) begin
          energy_q <= e_acc_d;
          magnet_q <= m_acc_d;
          obs_q    <= 1'b1;
        end
      end else begin
        row_q <= '0;
      end
    end
  end

  assign host.rd_data   = spin_q[host.rd_row];
  assign host.busy      = (state_q != StIdle);
  assign host.done      = done_q;
  assign host.obs_valid = obs_q;
  assign host.energy    = energy_q;
  assign host.magnet    = magnet_q;
  assign host.sweep_cnt = sweep_q;

endmodule

// File: tb/tb_ising_lattice_engine.sv
// Scoreboard bench: expected samples are queued at stimulus time and popped on each obs_valid.
module tb_ising_lattice_engine;

  localparam int N = 8;

  typedef struct {
    int e;
    int m;
    int sc;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ising_lattice_engine_if #(.N(8), .SWEEP_W(16)) b1 ();
  ising_lattice_engine_if #(.N(8), .SWEEP_W(16)) b2 ();

  ising_lattice_engine #(.N(8), .MEAS_EVERY(1), .SWEEP_W(16)) dut1 (
    .clk  (clk),
    .reset(reset),
    .host (b1)
  );

  ising_lattice_engine #(.N(8), .MEAS_EVERY(4), .SWEEP_W(16)) dut2 (
    .clk  (clk),
    .reset(reset),
    .host (b2)
  );

  int vectors = 0;
  int errors  = 0;
  obs_t q1[$];
  obs_t q2[$];

  int          ms [N][N];
  logic [31:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input int e, input int m, input int sc);
    obs_t o;
    o.e = e;
    o.m = m;
    o.sc = sc;
    if (sel == 0) q1.push_back(o);
    else q2.push_back(o);
  endtask

  always @(negedge clk) begin
    obs_t x;
    if (b1.obs_valid) begin
      if (q1.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL obs1_unexpected: got sample sweep %0d, expected none", b1.sweep_cnt);
      end else begin
        x = q1.pop_front();
        check("obs1_energy", int'(b1.energy), x.e);
        check("obs1_magnet", int'(b1.magnet), x.m);
        check("obs1_sweep", int'(b1.sweep_cnt), x.sc);
      end
    end
    if (b2.obs_valid) begin
      if (q2.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL obs2_unexpected: got sample sweep %0d, expected none", b2.sweep_cnt);
      end else begin
        x = q2.pop_front();
        check("obs2_energy", int'(b2.energy), x.e);
        check("obs2_magnet", int'(b2.magnet), x.m);
        check("obs2_sweep", int'(b2.sweep_cnt), x.sc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int r, input logic [7:0] d);
    b1.load_en = 1'b1;
    b1.load_row = 3'(r);
    b1.load_data = d;
    tick();
    b1.load_en = 1'b0;
  endtask

  task automatic check_row(input string name, input int r, input logic [7:0] exp);
    b1.rd_row = 3'(r);
    #1;
    check(name, int'(b1.rd_data), int'(exp));
  endtask

  task automatic start_run(input int sel, input int ns, input logic [31:0] sd,
                           input logic [31:0] t4, input logic [31:0] t8);
    if (sel == 0) begin
      b1.num_sweeps = 16'(ns);
      b1.seed = sd;
      b1.thr4 = t4;
      b1.thr8 = t8;
      b1.start = 1'b1;
    end else begin
      b2.num_sweeps = 16'(ns);
      b2.seed = sd;
      b2.thr4 = t4;
      b2.thr8 = t8;
      b2.start = 1'b1;
    end
    tick();
    b1.start = 1'b0;
    b1.load_en = 1'b0;
    b2.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string name, input int exp_lat);
    int c = 0;
    logic seen = 1'b0;
    while (!seen && c < 5000) begin
      tick();
      c++;
      seen = (sel == 0) ? b1.done : b2.done;
    end
    check({name, "_done_latency"}, c, exp_lat);
    check({name, "_busy_at_done"}, int'((sel == 0) ? b1.busy : b2.busy), 0);
    check({name, "_pending_samples"}, (sel == 0) ? q1.size() : q2.size(), 0);
  endtask

  // Reference Metropolis half-sweep written in spin-sum form
  task automatic model_half(input int colour, input logic [31:0] t4, input logic [31:0] t8);
    int old [N][N];
    int sum;
    int de;
    logic [31:0] r;
    old = ms;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((i + j) % 2 == colour) begin
          sum = old[(i + 1) % N][j] + old[(i + N - 1) % N][j]
              + old[i][(j + 1) % N] + old[i][(j + N - 1) % N];
          de = 2 * old[i][j] * sum;
          r = m_lfsr ^ (32'(i * N + j) * 32'h9E3779B9);
          if (de <= 0 || (de == 4 && r < t4) || (de == 8 && r < t8)) ms[i][j] = -old[i][j];
        end
      end
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
  endtask

  task automatic model_sample(input int sc);
    int e = 0;
    int m = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e -= ms[i][j] * ms[i][(j + 1) % N] + ms[i][j] * ms[(i + 1) % N][j];
        m += ms[i][j];
      end
    end
    push(0, e, m, sc);
  endtask

  task automatic model_run(input int ns, input logic [31:0] sd,
                           input logic [31:0] t4, input logic [31:0] t8);
    m_lfsr = (sd == 0) ? 32'h1 : sd;
    if (ns == 0) model_sample(0);
    for (int k = 1; k <= ns; k++) begin
      model_half(0, t4, t8);
      model_half(1, t4, t8);
      model_sample(k);
    end
  endtask

  task automatic check_model_rows(input string name);
    logic [7:0] exp;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) exp[j] = (ms[i][j] > 0);
      check_row(name, i, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic d;
    reset = 1'b1;
    {b1.start, b1.abort, b1.load_en, b1.load_row, b1.load_data, b1.rd_row} = '0;
    {b1.num_sweeps, b1.seed, b1.thr4, b1.thr8} = '0;
    {b2.start, b2.abort, b2.load_en, b2.load_row, b2.load_data, b2.rd_row} = '0;
    {b2.num_sweeps, b2.seed, b2.thr4, b2.thr8} = '0;
    #12;
    check("rst_busy", int'(b1.busy), 0);
    check("rst_done", int'(b1.done), 0);
    check("rst_obs_valid", int'(b1.obs_valid), 0);
    check("rst_energy", int'(b1.energy), 0);
    check("rst_magnet", int'(b1.magnet), 0);
    check("rst_sweep_cnt", int'(b1.sweep_cnt), 0);
    check_row("rst_row0", 0, 8'hFF);
    check_row("rst_row7", 7, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Zero sweeps: just a measurement of the reset lattice
    push(0, -128, 64, 0);
    start_run(0, 0, 32'h1, 32'h0, 32'h0);
    check("busy_after_start", int'(b1.busy), 1);
    wait_done(0, "zero_sweeps", 9);

    // Checkerboard, last row loaded in the same cycle as start
    for (int i = 0; i < 7; i++) load_row(i, (i % 2 == 0) ? 8'h55 : 8'hAA);
    b1.load_en = 1'b1;
    b1.load_row = 3'd7;
    b1.load_data = 8'hAA;
    push(0, -128, -64, 1);
    start_run(0, 1, 32'h5, 32'h0, 32'h0);
    wait_done(0, "checker", 11);
    for (int i = 0; i < N; i++) check_row("checker_row", i, 8'h00);

    // Ferromagnet at zero temperature stays put
    for (int i = 0; i < N; i++) load_row(i, 8'hFF);
    for (int k = 1; k <= 5; k++) push(0, -128, 64, k);
    start_run(0, 5, 32'h77, 32'h0, 32'h0);
    wait_done(0, "ferro5", 51);

    // Sparse sampling on the second engine
    push(1, -128, 64, 4);
    push(1, -128, 64, 8);
    push(1, -128, 64, 10);
    start_run(1, 10, 32'h9, 32'h0, 32'h0);
    wait_done(1, "meas_every4", 45);

    // Abort during the grey half of sweep 3; start/load while busy are ignored
    push(0, -128, 64, 1);
    push(0, -128, 64, 2);
    start_run(0, 5, 32'h3, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    b1.start = 1'b1;
    b1.load_en = 1'b1;
    b1.load_row = 3'd0;
    b1.load_data = 8'h00;
    tick();
    b1.start = 1'b0;
    b1.load_en = 1'b0;
    for (int c = 6; c < 21; c++) tick();
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    check("abort_busy", int'(b1.busy), 0);
    d = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      d = d | b1.done;
    end
    check("abort_no_done", int'(d), 0);
    check("abort_pending_samples", q1.size(), 0);
    check_row("abort_row0_kept", 0, 8'hFF);
    push(0, -128, 64, 1);
    start_run(0, 1, 32'h3, 32'h0, 32'h0);
    wait_done(0, "rerun", 11);

    // Finite temperature against the reference model
    for (int i = 0; i < N; i++) begin
      pat = 8'((i * 59) ^ 150);
      load_row(i, pat);
      for (int j = 0; j < N; j++) ms[i][j] = pat[j] ? 1 : -1;
    end
    model_run(200, 32'h1234ABCD, 32'h2A000000, 32'h07000000);
    start_run(0, 200, 32'h1234ABCD, 32'h2A000000, 32'h07000000);
    wait_done(0, "random200", 2001);
    check_model_rows("random200_row");

    // Seed 0 maps to LFSR state 1
    model_run(3, 32'h0, 32'h2A000000, 32'h07000000);
    start_run(0, 3, 32'h0, 32'h2A000000, 32'h07000000);
    wait_done(0, "seed0", 31);
    check_model_rows("seed0_row");

    // Asynchronous reset in the middle of a run
    start_run(0, 5, 32'h42, 32'h2A000000, 32'h07000000);
    for (int c = 0; c < 6; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy", int'(b1.busy), 0);
    check("areset_energy", int'(b1.energy), 0);
    check("areset_magnet", int'(b1.magnet), 0);
    check("areset_sweep_cnt", int'(b1.sweep_cnt), 0);
    check_row("areset_row3", 3, 8'hFF);
    #10;
    reset = 1'b0;
    tick();
    tick();
    check("final_q1_empty", q1.size(), 0);
    check("final_q2_empty", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
